instr_exec_unit: RTL and testbench

Parametrised instruction decode-and-execute unit: accepts one instruction word per handshake, decodes opcode/register/immediate fields, executes against an internal register file with zero/carry flags, and supports halt/resume. Generalises the fixed 8-bit, 8-register decoder to configurable data width and register count, and adds a valid/ready handshake, ALU ops, flags, illegal-opcode detection and a debug read port. It sits between the instruction source (fetch/testbench) and the rest of the datapath.

---
 rtl/instr_exec_pkg.sv | 31 +++
 rtl/instr_alu.sv | 41 ++++
 rtl/instr_exec_unit.sv | 100 ++++++++++
 tb/tb_instr_exec_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_exec_pkg.sv
// instr_exec_pkg: opcodes, FSM states and instruction field positions for instr_exec_unit.
package instr_exec_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HALTED} state_t;

    function automatic int op_lsb(int aw, int dw);
        return 2 * aw + dw;
    endfunction

    function automatic int rd_lsb(int aw, int dw);
        return aw + dw;
    endfunction

    function automatic int rs_lsb(int dw);
        return dw;
    endfunction

endpackage

// File: rtl/instr_alu.sv
// instr_alu: combinational ALU; arithmetic in DATA_W+1 bits so the top bit is carry/borrow.
module instr_alu
    import instr_exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              writes_rd,
    output logic              updates_carry,
    output logic              is_illegal
);
    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_MOVI, OP_MOV:  wide = {1'b0, b};
            OP_INC:           wide = {1'b0, a} + (DATA_W+1)'(1);
            OP_DEC:           wide = {1'b0, a} - (DATA_W+1)'(1);
            OP_ADD, OP_ADDI:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:           wide = {1'b0, a} - {1'b0, b};
            OP_AND:           wide = {1'b0, a & b};
            OP_OR:            wide = {1'b0, a | b};
            OP_XOR:           wide = {1'b0, a ^ b};
            default:          wide = '0;
        endcase
    end

    assign result        = wide[DATA_W-1:0];
    assign carry         = wide[DATA_W];
    assign zero          = result == '0;
    assign writes_rd     = op inside {[OP_MOVI:OP_ADDI]};
    assign updates_carry = op inside {[OP_INC:OP_XOR], OP_ADDI};
    assign is_illegal    = op inside {[4'hB:4'hE]};

endmodule

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: handshaked decode/execute unit with register file, zero/carry flags and halt/resume.
module instr_exec_unit
    import instr_exec_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = $clog2(NREGS),
    parameter int INSTR_W = 4 + 2*ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               resume,
    output logic               wb_valid,
    output logic [ADDR_W-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               halted,
    output logic               illegal,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);
    localparam int OPL = op_lsb(ADDR_W, DATA_W);
    localparam int RDL = rd_lsb(ADDR_W, DATA_W);
    localparam int RSL = rs_lsb(DATA_W);

    state_t             state, state_nx;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREGS];
    logic [3:0]         op;
    logic [ADDR_W-1:0]  rd, rs;
    logic [DATA_W-1:0]  imm, opb, result;
    logic               carry, zero, writes_rd, updates_carry, is_illegal;

    assign op          = ir[OPL +: 4];
    assign rd          = ir[RDL +: ADDR_W];
    assign rs          = ir[RSL +: ADDR_W];
    assign imm         = ir[DATA_W-1:0];
    assign opb         = (op == OP_MOVI || op == OP_ADDI) ? imm : regs[rs];
    assign instr_ready = state == ST_IDLE;
    assign halted      = state == ST_HALTED;
    assign dbg_data    = regs[dbg_addr];

    instr_alu #(.DATA_W(DATA_W)) u_alu (
        .op            (op),
        .a             (regs[rd]),
        .b             (opb),
        .result        (result),
        .carry         (carry),
        .zero          (zero),
        .writes_rd     (writes_rd),
        .updates_carry (updates_carry),
        .is_illegal    (is_illegal)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (instr_valid) state_nx = (instr[OPL +: 4] == OP_HALT) ? ST_HALTED : ST_EXEC;
            ST_EXEC:   state_nx = ST_IDLE;
            ST_HALTED: if (resume) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Writeback happens on the edge that leaves EXEC, so the next accepted instruction reads fresh values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ir         <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            if (instr_ready && instr_valid) ir <= instr;
            if (state == ST_EXEC) begin
                illegal <= is_illegal;
                if (writes_rd) begin
                    regs[rd]  <= result;
                    wb_valid  <= 1'b1;
                    wb_addr   <= rd;
                    wb_data   <= result;
                    zero_flag <= zero;
                end
                if (updates_carry) carry_flag <= carry;
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: random and directed stimulus against an arithmetic reference model.
module tb_instr_exec_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [17:0] instr = '0;
    logic        instr_valid = 0, resume = 0;
    logic        instr_ready, wb_valid, zero_flag, carry_flag, halted, illegal;
    logic [2:0]  wb_addr, dbg_addr = '0;
    logic [7:0]  wb_data, dbg_data;

    logic [27:0] instr16 = '0;
    logic        valid16 = 0;
    logic        ready16, wbv16, z16, c16, h16, ill16;
    logic [3:0]  wba16, dbga16 = '0;
    logic [15:0] wbd16, dbgd16;

    int checks = 0, failures = 0;
    int m [8];
    int mz = 0, mc = 0;

    always #5 clk = ~clk;

    instr_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .resume(resume), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .halted(halted), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    instr_exec_unit #(.DATA_W(16), .NREGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .instr(instr16), .instr_valid(valid16),
        .instr_ready(ready16), .resume(1'b0), .wb_valid(wbv16),
        .wb_addr(wba16), .wb_data(wbd16), .zero_flag(z16),
        .carry_flag(c16), .halted(h16), .illegal(ill16),
        .dbg_addr(dbga16), .dbg_data(dbgd16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic exec(input int op, input int rd, input int rs, input int imm);
        int a, b, v, w, t;
        for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
        if (!instr_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        instr = {4'(op), 3'(rd), 3'(rs), 8'(imm)};
        instr_valid = 1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 0;
        if (op == 15) begin
            chk("halt_halted", halted, 1);
            chk("halt_ready", instr_ready, 0);
            return;
        end
        chk("exec_busy", instr_ready, 0);
        a = m[rd];
        b = m[rs];
        imm = imm & 255;
        w = (op >= 1 && op <= 10);
        v = 0;
        case (op)
            1: v = imm;
            2: v = b;
            3: begin t = a + 1; v = t % 256; mc = (t > 255); end
            4: begin mc = (a < 1); v = (a + 255) % 256; end
            5: begin t = a + b; v = t % 256; mc = (t > 255); end
            6: begin mc = (a < b); v = (a - b + 256) % 256; end
            7: begin v = a & b; mc = 0; end
            8: begin v = a | b; mc = 0; end
            9: begin v = a ^ b; mc = 0; end
            10: begin t = a + imm; v = t % 256; mc = (t > 255); end
            default: ;
        endcase
        if (w) begin
            m[rd] = v;
            mz = (v == 0);
        end
        @(negedge clk);
        chk("wb_valid", wb_valid, w);
        chk("illegal", illegal, (op >= 11 && op <= 14));
        if (w) begin
            chk("wb_addr", wb_addr, rd);
            chk("wb_data", wb_data, v);
        end
        chk("zero", zero_flag, mz);
        chk("carry", carry_flag, mc);
        chk("ready_after", instr_ready, 1);
        dbg_addr = 3'(rd);
        #1;
        chk("dbg", dbg_data, m[rd]);
    endtask

    task automatic exec16(input int op, input int rd, input int imm);
        for (int i = 0; i < 20 && !ready16; i++) @(negedge clk);
        instr16 = {4'(op), 4'(rd), 4'd0, 16'(imm)};
        valid16 = 1;
        @(posedge clk);
        @(negedge clk);
        valid16 = 0;
        chk("w16_busy", ready16, 0);
        @(negedge clk);
        chk("w16_wbv", wbv16, 1);
        chk("w16_ready", ready16, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 0;
        #2;
        chk("rst_ready", instr_ready, 1);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_flags", {zero_flag, carry_flag, illegal}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        exec(1, 5, 0, 'hC9);
        exec(3, 5, 0, 0);
        chk("inc_c9", wb_data, 'hCA);
        exec(4, 5, 0, 0);
        chk("dec_ca", wb_data, 'hC9);

        exec(1, 1, 0, 'hFF);
        exec(3, 1, 0, 0);
        chk("inc_wrap", {zero_flag, carry_flag, wb_data}, {2'b11, 8'h00});
        exec(4, 1, 0, 0);
        chk("dec_borrow", {zero_flag, carry_flag, wb_data}, {2'b01, 8'hFF});

        exec(1, 2, 0, 'h0F);
        exec(1, 3, 0, 'hF0);
        exec(8, 2, 3, 0);
        chk("or_ff", wb_data, 'hFF);
        exec(9, 2, 2, 0);
        chk("xor_self", zero_flag, 1);
        exec(12, 2, 3, 'h11);
        exec(5, 5, 5, 0);
        exec(6, 5, 5, 0);
        chk("sub_self", {zero_flag, carry_flag}, 2'b10);

        exec(15, 0, 0, 0);
        instr = {4'h1, 3'd0, 3'd0, 8'h55};
        instr_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("halt_hold", instr_ready, 0);
        end
        resume = 1;
        @(posedge clk);
        @(negedge clk);
        resume = 0;
        instr_valid = 0;
        chk("resume_halted", halted, 0);
        chk("resume_ready", instr_ready, 1);
        dbg_addr = 0;
        #1;
        chk("halt_r0", dbg_data, 0);
        @(negedge clk);
        exec(1, 0, 0, 'h55);
        chk("resume_r0", dbg_data, 'h55);

        for (int n = 0; n < 300; n++)
            exec($urandom_range(0, 14), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
        exec(15, 0, 0, 0);
        resume = 1;
        @(negedge clk);
        resume = 0;
        @(negedge clk);
        resume = 1;
        @(negedge clk);
        resume = 0;
        chk("resume_idle_ignored", {halted, instr_ready}, 2'b01);

        exec16(1, 15, 'hFFFF);
        chk("w16_movi", wbd16, 'hFFFF);
        exec16(10, 15, 'h0002);
        chk("w16_addi", {c16, wbd16}, {1'b1, 16'h0001});
        exec16(1, 3, 'h1234);
        exec16(1, 4, 'h0000);
        chk("w16_zero", {z16, wba16}, {1'b1, 4'd4});

        @(negedge clk);
        instr = {4'h1, 3'd4, 3'd0, 8'hAA};
        instr_valid = 1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 0;
        rst_n = 0;
        for (int i = 0; i < 8; i++) m[i] = 0;
        dbg_addr = 4;
        #1;
        chk("arst_ready", instr_ready, 1);
        chk("arst_wb", {wb_valid, wb_addr, wb_data}, 0);
        chk("arst_flags", {zero_flag, carry_flag, halted, illegal}, 0);
        chk("arst_r4", dbg_data, 0);
        dbg_addr = 5;
        #1;
        chk("arst_r5", dbg_data, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_wb", wb_valid, 0);
        end
        dbg_addr = 4;
        #1;
        chk("arst_r4_after", dbg_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
